// File: rtl/dtu_word_pkg.sv
// Shared types, prefix constants and the sample extraction helper for the
// LiTe-DTU lane-0 word unpacker.
package dtu_word_pkg;

    localparam int WORD_W     = 32;
    localparam int SMP_W      = 13;
    localparam int BL_FIELD_W = 6;

    typedef enum logic [3:0] {
        W_BL5,
        W_BLN,
        W_SIG2,
        W_SIG1,
        W_HDR,
        W_IDLE,
        W_RST,
        W_TRL,
        W_ERR
    } word_type_t;

    typedef enum logic {
        S_IDLE,
        S_UNPACK
    } state_t;

    // Prefix masks and match values, checked in this order (first match wins).
    localparam logic [WORD_W-1:0] MASK_BL5  = 32'hC000_0000;
    localparam logic [WORD_W-1:0] VAL_BL5   = 32'h4000_0000;
    localparam logic [WORD_W-1:0] MASK_BLN  = 32'hC000_0000;
    localparam logic [WORD_W-1:0] VAL_BLN   = 32'h8000_0000;
    localparam logic [WORD_W-1:0] MASK_SIG2 = 32'hFC00_0000;
    localparam logic [WORD_W-1:0] VAL_SIG2  = 32'h2800_0000;
    localparam logic [WORD_W-1:0] MASK_SIG1 = 32'hFE00_0000;
    localparam logic [WORD_W-1:0] VAL_SIG1  = 32'h2C00_0000;
    localparam logic [WORD_W-1:0] MASK_HDR  = 32'hFE00_0000;
    localparam logic [WORD_W-1:0] VAL_HDR   = 32'h2E00_0000;
    localparam logic [WORD_W-1:0] MASK_IDLE = 32'hF000_0000;
    localparam logic [WORD_W-1:0] VAL_IDLE  = 32'hE000_0000;
    localparam logic [WORD_W-1:0] MASK_RST  = 32'hFC00_0000;
    localparam logic [WORD_W-1:0] VAL_RST   = 32'h3400_0000;
    localparam logic [WORD_W-1:0] MASK_TRL  = 32'hF000_0000;
    localparam logic [WORD_W-1:0] VAL_TRL   = 32'hD000_0000;

    // Sample k of a payload word. Only bits [29:0] ever carry payload, so the
    // prefix bits are not passed in.
    function automatic logic [SMP_W-1:0] extract_sample(
        input logic [29:0] w,
        input logic        baseline,
        input logic [2:0]  idx
    );
        logic [BL_FIELD_W-1:0] f;
        logic [SMP_W-1:0]      s;
        case (idx)
            3'd0:    f = w[5:0];
            3'd1:    f = w[11:6];
            3'd2:    f = w[17:12];
            3'd3:    f = w[23:18];
            3'd4:    f = w[29:24];
            default: f = '0;
        endcase
        if (baseline) begin
            s = {{(SMP_W-BL_FIELD_W){1'b0}}, f};
        end else if (idx[0]) begin
            s = {w[25], w[24:13]};
        end else begin
            s = {w[12], w[11:0]};
        end
        return s;
    endfunction

endpackage

// File: rtl/dtu_word_classify.sv
// Combinational word classifier: prefix decode with first-match priority and
// the number of samples the word carries (0 for non-sample or bad BASELINEN).
module dtu_word_classify
    import dtu_word_pkg::*;
(
    input  logic [WORD_W-1:0] word_data,
    output word_type_t        word_type,
    output logic [2:0]        n_smp
);

    // Priority decode of the word prefix.
    always_comb begin
        word_type = W_ERR;
        n_smp     = 3'd0;
        if ((word_data & MASK_BL5) == VAL_BL5) begin
            word_type = W_BL5;
            n_smp     = 3'd5;
        end else if ((word_data & MASK_BLN) == VAL_BLN) begin
            word_type = W_BLN;
            if ((word_data[26:24] >= 3'd1) && (word_data[26:24] <= 3'd4)) begin
                n_smp = word_data[26:24];
            end
        end else if ((word_data & MASK_SIG2) == VAL_SIG2) begin
            word_type = W_SIG2;
            n_smp     = 3'd2;
        end else if ((word_data & MASK_SIG1) == VAL_SIG1) begin
            word_type = W_SIG1;
            n_smp     = 3'd1;
        end else if ((word_data & MASK_HDR) == VAL_HDR) begin
            word_type = W_HDR;
        end else if ((word_data & MASK_IDLE) == VAL_IDLE) begin
            word_type = W_IDLE;
        end else if ((word_data & MASK_RST) == VAL_RST) begin
            word_type = W_RST;
        end else if ((word_data & MASK_TRL) == VAL_TRL) begin
            word_type = W_TRL;
        end
    end

endmodule

// File: rtl/dtu_word_unpacker.sv
// LiTe-DTU lane-0 word unpacker: accepts aligned 32-bit words, streams
// baseline/signal samples one per cycle, and tracks frames, errors and
// RESET words.
//
// state    | meaning
// S_IDLE   | no sample pending, word_ready=1
// S_UNPACK | presenting sample idx_q of the latched word
module dtu_word_unpacker
    import dtu_word_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk_160,
    input  logic              rst,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    input  logic              calib_busy,
    input  logic              test_enable,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [SMP_W-1:0]  smp_data,
    output logic              smp_baseline,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              dtu_reset_seen
);

    word_type_t        word_type;
    logic [2:0]        n_smp;

    state_t            state_q, state_d;
    logic [29:0]       word_q, word_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        last_q, last_d;
    logic              smp_valid_q, smp_valid_d;
    logic [SMP_W-1:0]  smp_data_q, smp_data_d;
    logic              smp_baseline_q, smp_baseline_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              in_frame_q, in_frame_d;
    logic              rst_seen_q, rst_seen_d;

    logic              hs;
    logic              last_smp;
    logic              accept;
    logic              decode;
    logic              load;
    logic              is_bl;
    logic              frame_inc;
    logic              err_inc;

    dtu_word_classify u_classify (
        .word_data (word_data),
        .word_type (word_type),
        .n_smp     (n_smp)
    );

    // Handshake decode; a new word is taken in IDLE or alongside the last sample.
    always_comb begin
        hs         = smp_valid_q & smp_ready;
        last_smp   = (idx_q == last_q);
        word_ready = ~rst & ((state_q == S_IDLE) | (hs & last_smp));
        accept     = word_valid & word_ready;
        decode     = accept & ~calib_busy & ~test_enable;
        load       = decode & (n_smp != 3'd0);
        is_bl      = (word_type == W_BL5) | (word_type == W_BLN);
    end

    // Next-state and registered sample outputs.
    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        idx_d          = idx_q;
        last_d         = last_q;
        smp_valid_d    = smp_valid_q;
        smp_data_d     = smp_data_q;
        smp_baseline_d = smp_baseline_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d        = S_UNPACK;
                    word_d         = word_data[29:0];
                    idx_d          = 3'd0;
                    last_d         = n_smp - 3'd1;
                    smp_valid_d    = 1'b1;
                    smp_data_d     = extract_sample(word_data[29:0], is_bl, 3'd0);
                    smp_baseline_d = is_bl;
                end
            end
            S_UNPACK: begin
                if (hs) begin
                    if (!last_smp) begin
                        idx_d      = idx_q + 3'd1;
                        smp_data_d = extract_sample(word_q, smp_baseline_q, idx_q + 3'd1);
                    end else if (load) begin
                        word_d         = word_data[29:0];
                        idx_d          = 3'd0;
                        last_d         = n_smp - 3'd1;
                        smp_data_d     = extract_sample(word_data[29:0], is_bl, 3'd0);
                        smp_baseline_d = is_bl;
                    end else begin
                        state_d     = S_IDLE;
                        smp_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                smp_valid_d = 1'b0;
            end
        endcase
    end

    // Frame tracking, saturating counters and the RESET-word pulse.
    always_comb begin
        frame_inc  = decode & (word_type == W_TRL) & in_frame_q;
        err_inc    = decode & ((word_type == W_ERR)
                             | ((word_type == W_BLN) & (n_smp == 3'd0))
                             | ((word_type == W_HDR) & in_frame_q)
                             | ((word_type == W_TRL) & ~in_frame_q));
        in_frame_d = in_frame_q;
        if (decode) begin
            if (word_type == W_HDR) begin
                in_frame_d = 1'b1;
            end else if ((word_type == W_RST) || (word_type == W_TRL)) begin
                in_frame_d = 1'b0;
            end
        end
        rst_seen_d  = decode & (word_type == W_RST);
        frame_cnt_d = frame_cnt_q;
        if (frame_inc && (frame_cnt_q != {CNT_W{1'b1}})) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_160) begin
        if (rst) begin
            state_q        <= S_IDLE;
            word_q         <= '0;
            idx_q          <= '0;
            last_q         <= '0;
            smp_valid_q    <= 1'b0;
            smp_data_q     <= '0;
            smp_baseline_q <= 1'b0;
            frame_cnt_q    <= '0;
            err_cnt_q      <= '0;
            in_frame_q     <= 1'b0;
            rst_seen_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            idx_q          <= idx_d;
            last_q         <= last_d;
            smp_valid_q    <= smp_valid_d;
            smp_data_q     <= smp_data_d;
            smp_baseline_q <= smp_baseline_d;
            frame_cnt_q    <= frame_cnt_d;
            err_cnt_q      <= err_cnt_d;
            in_frame_q     <= in_frame_d;
            rst_seen_q     <= rst_seen_d;
        end
    end

    assign smp_valid      = smp_valid_q;
    assign smp_data       = smp_data_q;
    assign smp_baseline   = smp_baseline_q;
    assign frame_cnt      = frame_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign dtu_reset_seen = rst_seen_q;

endmodule

// File: tb/tb_dtu_word_unpacker.sv
// Directed, table-driven bench for dtu_word_unpacker.
module tb_dtu_word_unpacker;

    logic        clk_160 = 1'b0;
    logic        rst;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        calib_busy;
    logic        test_enable;
    logic        smp_valid;
    logic        smp_ready;
    logic [12:0] smp_data;
    logic        smp_baseline;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        dtu_reset_seen;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frame = 0;
    int exp_err   = 0;

    typedef struct {
        logic [31:0]      word;
        logic             cal;
        logic             tst;
        int               n;
        logic [4:0][12:0] smp;
        logic             bl;
        int               df;
        int               de;
        logic             rp;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    always #5 clk_160 = ~clk_160;

    dtu_word_unpacker #(.CNT_W(16)) dut (
        .clk_160        (clk_160),
        .rst            (rst),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .word_data      (word_data),
        .calib_busy     (calib_busy),
        .test_enable    (test_enable),
        .smp_valid      (smp_valid),
        .smp_ready      (smp_ready),
        .smp_data       (smp_data),
        .smp_baseline   (smp_baseline),
        .frame_cnt      (frame_cnt),
        .err_cnt        (err_cnt),
        .dtu_reset_seen (dtu_reset_seen)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endtask

    function automatic vec_t mk(input logic [31:0] w, input logic c, input logic t, input int n,
                                input logic [12:0] s0, input logic [12:0] s1, input logic [12:0] s2,
                                input logic [12:0] s3, input logic [12:0] s4, input logic bl,
                                input int df, input int de, input logic rp);
        vec_t v;
        v.word = w; v.cal = c; v.tst = t; v.n = n;
        v.smp[0] = s0; v.smp[1] = s1; v.smp[2] = s2; v.smp[3] = s3; v.smp[4] = s4;
        v.bl = bl; v.df = df; v.de = de; v.rp = rp;
        return v;
    endfunction

    // Present one word, wait for acceptance, then drain and check its samples.
    // Called and returns on a negedge.
    task automatic send_vec(input vec_t v);
        int guard;
        int k;
        int rdy_low;
        word_data   = v.word;
        calib_busy  = v.cal;
        test_enable = v.tst;
        word_valid  = 1'b1;
        smp_ready   = 1'b1;
        guard = 0;
        while (!word_ready && guard < 50) begin
            @(negedge clk_160);
            guard++;
        end
        if (guard >= 50) timeout("accept");
        @(negedge clk_160);
        word_valid  = 1'b0;
        calib_busy  = 1'b0;
        test_enable = 1'b0;
        exp_frame += v.df;
        exp_err   += v.de;
        chk("first_valid", {31'b0, smp_valid}, {31'b0, (v.n != 0)});
        chk("reset_pulse", {31'b0, dtu_reset_seen}, {31'b0, v.rp});
        chk("frame_cnt", {16'b0, frame_cnt}, exp_frame);
        chk("err_cnt", {16'b0, err_cnt}, exp_err);
        k = 0;
        rdy_low = 0;
        guard = 0;
        while (smp_valid && guard < 20) begin
            if (k < 5) begin
                chk("smp_data", {19'b0, smp_data}, {19'b0, v.smp[k]});
                chk("smp_baseline", {31'b0, smp_baseline}, {31'b0, v.bl});
            end
            if (!word_ready) rdy_low++;
            k++;
            guard++;
            @(negedge clk_160);
        end
        if (guard >= 20) timeout("drain");
        chk("n_samples", k, v.n);
        if (v.n != 0) chk("ready_low_cycles", rdy_low, v.n - 1);
        @(negedge clk_160);
        chk("no_extra_sample", {31'b0, smp_valid}, 32'd0);
        chk("reset_pulse_clr", {31'b0, dtu_reset_seen}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] rexp[13];
        int got;

        rst = 1'b1; word_valid = 1'b0; word_data = '0;
        calib_busy = 1'b0; test_enable = 1'b0; smp_ready = 1'b1;

        repeat (3) @(negedge clk_160);
        chk("rst_word_ready", {31'b0, word_ready}, 32'd0);
        chk("rst_smp_valid", {31'b0, smp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk_160);
        chk("init_word_ready", {31'b0, word_ready}, 32'd1);
        chk("init_smp_valid", {31'b0, smp_valid}, 32'd0);
        chk("init_smp_data", {19'b0, smp_data}, 32'd0);
        chk("init_smp_baseline", {31'b0, smp_baseline}, 32'd0);
        chk("init_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        chk("init_err_cnt", {16'b0, err_cnt}, 32'd0);
        chk("init_reset_seen", {31'b0, dtu_reset_seen}, 32'd0);

        //           word          cal  tst  n  s0       s1       s2       s3     s4     bl  df de rp
        vecs[0]  = mk(32'h4510_3081, 0, 0, 5, 13'h001, 13'h002, 13'h003, 13'h004, 13'h005, 1, 0, 0, 0);
        vecs[1]  = mk(32'h2B57_9123, 0, 0, 2, 13'h1123, 13'h1ABC, 0, 0, 0,                 0, 0, 0, 0);
        vecs[2]  = mk(32'h2E00_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 0, 0);
        vecs[3]  = mk(32'h2C10_05A5, 0, 0, 1, 13'h05A5, 0, 0, 0, 0,                        0, 0, 0, 0);
        vecs[4]  = mk(32'hD000_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 1, 0, 0);
        vecs[5]  = mk(32'hD000_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 1, 0);
        vecs[6]  = mk(32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 1, 0);
        vecs[7]  = mk(32'h8500_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 1, 0);
        vecs[8]  = mk(32'h83FE_A57F, 0, 0, 3, 13'h03F, 13'h015, 13'h02A, 0, 0,            1, 0, 0, 0);
        vecs[9]  = mk(32'hE123_4567, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 0, 0);
        vecs[10] = mk(32'h2E00_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 0, 0);
        vecs[11] = mk(32'h3400_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 0, 1);
        vecs[12] = mk(32'hD000_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 1, 0);
        vecs[13] = mk(32'h4510_3081, 1, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 0, 0);
        vecs[14] = mk(32'hD000_0000, 0, 1, 0, 0, 0, 0, 0, 0,                               0, 0, 0, 0);
        vecs[15] = mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 1, 0);
        vecs[16] = mk(32'h2E00_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 0, 0);
        vecs[17] = mk(32'h2E00_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 0, 1, 0);
        vecs[18] = mk(32'hD000_0000, 0, 0, 0, 0, 0, 0, 0, 0,                               0, 1, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            send_vec(vecs[i]);
        end

        // Back-to-back words against a randomly stalling consumer.
        rexp = '{13'h1123, 13'h1ABC, 13'h001, 13'h002, 13'h003, 13'h004, 13'h005,
                 13'h05A5, 13'h001, 13'h002, 13'h003, 13'h004, 13'h005};
        got = 0;
        fork
            begin : upstream
                logic [31:0] words[4];
                int g;
                words = '{32'h2B57_9123, 32'h4510_3081, 32'h2C10_05A5, 32'h4510_3081};
                for (int w = 0; w < 4; w++) begin
                    word_data  = words[w];
                    word_valid = 1'b1;
                    g = 0;
                    while (!word_ready && g < 200) begin
                        @(negedge clk_160);
                        g++;
                    end
                    if (g >= 200) timeout("rand_accept");
                    @(negedge clk_160);
                end
                word_valid = 1'b0;
            end
            begin : downstream
                logic        stalled;
                logic [12:0] held;
                stalled = 1'b0;
                held    = '0;
                for (int cyc = 0; cyc < 400 && got < 13; cyc++) begin
                    @(posedge clk_160);
                    #1 smp_ready = 1'($urandom_range(0, 1));
                    @(negedge clk_160);
                    if (stalled && smp_valid) chk("hold_stable", {19'b0, smp_data}, {19'b0, held});
                    if (smp_valid && smp_ready) begin
                        chk("rand_smp_data", {19'b0, smp_data}, {19'b0, rexp[got]});
                        got++;
                    end
                    stalled = smp_valid & ~smp_ready;
                    held    = smp_data;
                end
            end
        join
        smp_ready = 1'b1;
        chk("rand_count", got, 13);
        repeat (2) @(negedge clk_160);
        chk("rand_no_dup", {31'b0, smp_valid}, 32'd0);

        // Reset while sample 3 of a BASELINE5 word is pending.
        word_data  = 32'h4510_3081;
        word_valid = 1'b1;
        begin
            int g;
            g = 0;
            while (!word_ready && g < 50) begin
                @(negedge clk_160);
                g++;
            end
            if (g >= 50) timeout("rst_accept");
        end
        @(negedge clk_160);
        word_valid = 1'b0;
        smp_ready  = 1'b1;
        chk("pre_rst_s1", {19'b0, smp_data}, 32'h001);
        @(negedge clk_160);
        @(negedge clk_160);
        chk("pre_rst_s3", {19'b0, smp_data}, 32'h003);
        chk("pre_rst_valid", {31'b0, smp_valid}, 32'd1);
        smp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk_160);
        chk("mid_rst_word_ready", {31'b0, word_ready}, 32'd0);
        chk("mid_rst_smp_valid", {31'b0, smp_valid}, 32'd0);
        chk("mid_rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        chk("mid_rst_err_cnt", {16'b0, err_cnt}, 32'd0);
        rst = 1'b0;
        smp_ready = 1'b1;
        @(negedge clk_160);
        chk("post_rst_word_ready", {31'b0, word_ready}, 32'd1);
        chk("post_rst_smp_valid", {31'b0, smp_valid}, 32'd0);
        exp_frame = 0;
        exp_err   = 0;
        send_vec(vecs[1]);
        send_vec(vecs[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
